// File: rtl/mas_pkg.sv
// mas_pkg: shared encodings for the modular adder-subtractor (MAS) sequential unit.
//   SEL_*  : operation select codes on sel
//   CMP_*  : correction codes reported on cmp
//   state_e: control FSM states of mas_seq_unit
package mas_pkg;

   localparam logic [1:0] SEL_ADD  = 2'b00;
   localparam logic [1:0] SEL_SUB  = 2'b11;

   localparam logic [1:0] CMP_NONE = 2'b00;
   localparam logic [1:0] CMP_SUBQ = 2'b01;
   localparam logic [1:0] CMP_ADDQ = 2'b10;
   localparam logic [1:0] CMP_ERR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      CORR = 2'b10,
      DONE = 2'b11
   } state_e;

endpackage : mas_pkg

// File: rtl/mas_mod_core.sv
// mas_mod_core: combinational modular correction of a raw sum/difference.
// Ports:
//   i_raw     [W:0]   raw result, two's complement in W+1 bits
//   i_q       [W-1:0] modulus
//   i_sub             1 = subtraction, 0 = addition
//   i_illegal         transaction flagged illegal
//   o_dout    [W-1:0] reduced result (0 when illegal)
//   o_cmp     [1:0]   correction code
//   o_err             illegal transaction
module mas_mod_core
   import mas_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic [W:0]   i_raw,
   input  logic [W-1:0] i_q,
   input  logic         i_sub,
   input  logic         i_illegal,
   output logic [W-1:0] o_dout,
   output logic [1:0]   o_cmp,
   output logic         o_err
);

   logic [W:0]   w_q_ext;
   logic [W:0]   w_raw_minus_q;
   logic [W-1:0] w_raw_plus_q;

   assign w_q_ext       = {1'b0, i_q};
   assign w_raw_minus_q = i_raw - w_q_ext;
   // A negative difference plus q always lands in 0..q-1, so the carry out is dropped.
   assign w_raw_plus_q  = i_raw[W-1:0] + i_q;

   always_comb begin
      o_dout = i_raw[W-1:0];
      o_cmp  = CMP_NONE;
      o_err  = 1'b0;
      if (i_illegal) begin
         o_dout = '0;
         o_cmp  = CMP_ERR;
         o_err  = 1'b1;
      end else if (!i_sub && (i_raw >= w_q_ext)) begin
         o_dout = w_raw_minus_q[W-1:0];
         o_cmp  = CMP_SUBQ;
      end else if (i_sub && i_raw[W]) begin
         o_dout = w_raw_plus_q;
         o_cmp  = CMP_ADDQ;
      end
   end

endmodule : mas_mod_core

// File: rtl/mas_seq_unit.sv
// mas_seq_unit: handshaked sequential (din1 +/- din2) mod q responder.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_in_valid / o_in_ready        operand channel (i_din1, i_din2, i_q, i_sel)
//   o_out_valid / i_out_ready      result channel (o_dout, o_cmp, o_err)
//   o_op_count [CNT_W-1:0]         completed transactions, saturating
// Flow: IDLE --accept--> CALC --> CORR --> DONE --out_ready--> IDLE.
module mas_seq_unit
   import mas_pkg::*;
#(
   parameter int unsigned W     = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [W-1:0]     i_din1,
   input  logic [W-1:0]     i_din2,
   input  logic [W-1:0]     i_q,
   input  logic [1:0]       i_sel,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [W-1:0]     o_dout,
   output logic [1:0]       o_cmp,
   output logic             o_err,
   output logic [CNT_W-1:0] o_op_count
);

   state_e           r_state;
   state_e           w_state_next;

   logic [W-1:0]     r_din1;
   logic [W-1:0]     r_din2;
   logic [W-1:0]     r_q;
   logic [1:0]       r_sel;
   logic [W:0]       r_raw;
   logic             r_illegal;
   logic [W-1:0]     r_dout;
   logic [1:0]       r_cmp;
   logic             r_err;
   logic [CNT_W-1:0] r_op_count;

   logic             w_accept;
   logic             w_release;
   logic             w_is_sub;
   logic [W:0]       w_raw;
   logic             w_illegal;
   logic [W-1:0]     w_core_dout;
   logic [1:0]       w_core_cmp;
   logic             w_core_err;

   // Handshake flags come straight from the state register.
   assign o_in_ready  = (r_state == IDLE);
   assign o_out_valid = (r_state == DONE);
   assign w_accept    = i_in_valid && (r_state == IDLE);
   assign w_release   = i_out_ready && (r_state == DONE);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (i_in_valid) w_state_next = CALC;
         CALC:    w_state_next = CORR;
         CORR:    w_state_next = DONE;
         DONE:    if (i_out_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // ---------------- CALC datapath ----------------
   // Illegal sel codes fall through to the add path; the result is discarded anyway.
   assign w_is_sub  = (r_sel == SEL_SUB);
   assign w_raw     = w_is_sub ? ({1'b0, r_din1} - {1'b0, r_din2})
                               : ({1'b0, r_din1} + {1'b0, r_din2});
   assign w_illegal = (r_q <= W'(1)) || (r_din1 >= r_q) || (r_din2 >= r_q) ||
                      ((r_sel != SEL_ADD) && (r_sel != SEL_SUB));

   // ---------------- CORR datapath ----------------
   mas_mod_core #(
      .W (W)
   ) u_mod_core (
      .i_raw     (r_raw),
      .i_q       (r_q),
      .i_sub     (w_is_sub),
      .i_illegal (r_illegal),
      .o_dout    (w_core_dout),
      .o_cmp     (w_core_cmp),
      .o_err     (w_core_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_din1    <= '0;
         r_din2    <= '0;
         r_q       <= '0;
         r_sel     <= '0;
         r_raw     <= '0;
         r_illegal <= 1'b0;
         r_dout    <= '0;
         r_cmp     <= CMP_NONE;
         r_err     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_din1 <= i_din1;
            r_din2 <= i_din2;
            r_q    <= i_q;
            r_sel  <= i_sel;
         end
         if (r_state == CALC) begin
            r_raw     <= w_raw;
            r_illegal <= w_illegal;
         end
         // Results persist past the handshake until the next CORR overwrites them.
         if (r_state == CORR) begin
            r_dout <= w_core_dout;
            r_cmp  <= w_core_cmp;
            r_err  <= w_core_err;
         end
      end
   end

   // ---------------- completed-operation counter ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_count <= '0;
      end else if (w_release && (r_op_count != '1)) begin
         r_op_count <= r_op_count + CNT_W'(1);
      end
   end

   assign o_dout     = r_dout;
   assign o_cmp      = r_cmp;
   assign o_err      = r_err;
   assign o_op_count = r_op_count;

endmodule : mas_seq_unit

// File: doc/mas_seq_unit.md
Name: mas_seq_unit

Overview:
Sequential, handshaked responder for the modular adder-subtractor (MAS) datapath. It accepts one operand set (din1, din2, q, sel) per transaction on a valid/ready input channel. It computes (din1 ± din2) mod q through a registered 3-stage FSM and returns the result, the correction code and an error flag on a valid/ready output channel. It is the target that the MAS stimulus/checker environment and upstream controllers drive, instead of applying raw combinational inputs.

Parameters:
W, 4, operand/modulus/result width in bits
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set present
in_ready  output  1  unit can accept an operand set
din1  input  W  first operand; must be < q
din2  input  W  second operand; must be < q
q  input  W  modulus; legal range 2..2^W-1
sel  input  2  2'b00 add, 2'b11 subtract; 2'b01/2'b10 illegal
out_valid  output  1  result present
out_ready  input  1  consumer takes result
dout  output  W  reduced result
cmp  output  2  00 no correction, 01 raw>=q (q subtracted), 10 raw<0 (q added), 11 error
err  output  1  illegal transaction
op_count  output  CNT_W  completed transactions, saturating

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE, in_ready=1, out_valid=0, dout=0, cmp=2'b00, err=0, op_count=0, all operand registers 0.
- FSM states: IDLE, CALC, CORR, DONE.
- IDLE:
  - in_ready=1.
  - on in_valid && in_ready at edge E0: latch din1, din2, q, sel; go to CALC.
- CALC:
  - raw = {0,din1} + {0,din2} for add, or {0,din1} - {0,din2} for subtract, in W+1 bits two's complement.
  - compute illegal = (q<2) | (din1>=q) | (din2>=q) | (sel==01) | (sel==10).
  - register raw and illegal; go to CORR at E1.
- CORR:
  - if illegal: dout=0, cmp=11, err=1.
  - else if add and raw>=q: dout=raw-q, cmp=01.
  - else if sub and raw[W]=1 (negative): dout=raw+q (low W bits), cmp=10.
  - else: dout=raw[W-1:0], cmp=00.
  - register the outputs; go to DONE at E2.
- DONE:
  - out_valid=1.
  - dout/cmp/err are held stable while out_valid && !out_ready; backpressure is unbounded.
  - on out_ready at edge: out_valid=0, op_count increments (saturates at all-ones, no wrap, errors included), return to IDLE.
- Latency: out_valid first high after E2, i.e. 2 cycles after the accept edge. Throughput is at most one transaction per 4 cycles.
- in_ready=0 in CALC, CORR and DONE. in_valid in those states is ignored; no buffering or queuing.
- in_ready is a registered state decode. There is no combinational path from in_valid or out_ready to any output.
- Width rules:
  - add raw max 2^(W+1)-2, fits in W+1 bits.
  - sub raw range -(2^W-1)..(2^W-1).
  - legal results are always < q.
- Subtract with raw==0 → dout=0, cmp=00. Add with raw==q → dout=0, cmp=01.
- dout/cmp/err keep their last values after handshake until the next CORR stage overwrites them.
- rst_n asserted in any state, including mid-CALC/CORR or with out_valid high and out_ready low: immediate return to reset values. The in-flight transaction is dropped and op_count is cleared.
- Operands on din1/din2/q/sel may change freely outside the accept edge without effect.

Decomposition:
- Shared package mas_pkg:
  - SEL_ADD=2'b00, SEL_SUB=2'b11
  - CMP_NONE=2'b00, CMP_SUBQ=2'b01, CMP_ADDQ=2'b10, CMP_ERR=2'b11
  - state enum {IDLE, CALC, CORR, DONE}
- One sub-module, mas_mod_core: combinational raw→(dout, cmp) correction, parameterised by W.
- FSM, operand registers, handshake and counter stay in mas_seq_unit.

Test Plan:
- Add with overflow correction: 7+5 mod 11, sel=00 → out_valid 2 cycles after accept; dout=1, cmp=01, err=0; op_count=1 after out_ready.
- Add, no correction and boundary: 4+5 mod 13 → dout=9, cmp=00. Then 6+7 mod 13 → dout=0, cmp=01.
- Subtract, negative: 3-9 mod 13, sel=11 → dout=7, cmp=10. Then 9-9 mod 13 → dout=0, cmp=00.
- Errors:
  - q=0 → dout=0, cmp=11, err=1, same latency; op_count still increments.
  - din1=12 with q=12 → err=1.
  - sel=01 → err=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → dout/cmp/err stable and in_ready=0 throughout. A new in_valid pulse during this window is not accepted. After out_ready is asserted, in_ready=1 on the next cycle.
- Reset mid-op: accept 7+5 mod 11, drop rst_n during CORR → out_valid=0, in_ready=1, op_count=0 at once. After release, 2+2 mod 5 → dout=4, cmp=00.
